// File: rtl/fx_bus_master_if.sv
// rtl/fx_bus_master_if.sv - host byte streams and fx register bus bundle for fx_bus_master
interface fx_bus_master_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [21:0] fx_waddr;
    logic        fx_wr;
    logic [7:0]  fx_data;
    logic [21:0] fx_raddr;
    logic        fx_rd;
    logic [7:0]  fx_q;
    logic        busy;

    modport master (
        input  rx_data, rx_valid, tx_ready, fx_q,
        output rx_ready, tx_data, tx_valid, fx_waddr, fx_wr, fx_data, fx_raddr, fx_rd, busy
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, fx_q,
        input  rx_ready, tx_data, tx_valid, fx_waddr, fx_wr, fx_data, fx_raddr, fx_rd, busy
    );
endinterface

// File: rtl/fx_bus_master.sv
// rtl/fx_bus_master.sv - fx bus initiator: host command bytes to fx write/read strobes
// Optional command inactivity abort under macro FX_MASTER_TIMEOUT_EN.
module fx_bus_master #(
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 65535
) (
    input  logic              clk_sys,
    input  logic              rst,
    fx_bus_master_if.master   bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_ADDR2, S_ADDR1, S_ADDR0, S_LEN, S_WDATA,
        S_RISSUE, S_RWAIT, S_RSEND, S_ACK, S_ERR
    } state_t;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_ERR  = 8'h45;
    localparam logic [7:0] RSP_ACK  = 8'h4B;

    if (RD_LAT < 1 || RD_LAT > 4 || TIMEOUT < 1) begin : g_bad_param
        $error("fx_bus_master: RD_LAT must be 1..4 and TIMEOUT positive");
    end

    state_t      r_state;
    logic [21:0] r_addr;
    logic [8:0]  r_cnt;
    logic        r_is_wr;
    logic [2:0]  r_lat;
    logic        r_tx_valid;
    logic [7:0]  r_tx_data;
    logic        r_fx_wr;
    logic        r_fx_rd;
    logic [21:0] r_fx_waddr;
    logic [21:0] r_fx_raddr;
    logic [7:0]  r_fx_data;

    logic w_rx_state;
    logic w_rx_ready;
    logic w_rx_fire;
    logic w_tx_fire;
    logic w_tmo_hit;

    assign w_rx_state = (r_state == S_IDLE)  || (r_state == S_ADDR2) || (r_state == S_ADDR1) ||
                        (r_state == S_ADDR0) || (r_state == S_LEN)   || (r_state == S_WDATA);
    assign w_rx_ready = w_rx_state && !rst;
    assign w_rx_fire  = bus.rx_valid && w_rx_ready;
    assign w_tx_fire  = r_tx_valid && bus.tx_ready;

`ifdef FX_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] r_tmo;
    logic             w_tmo_state;

    // Counts idle cycles only while the host still owes us command bytes.
    assign w_tmo_state = w_rx_state && (r_state != S_IDLE);
    assign w_tmo_hit   = w_tmo_state && !w_rx_fire && (r_tmo == TMO_W'(TIMEOUT));

    always_ff @(posedge clk_sys) begin
        if (rst || !w_tmo_state || w_rx_fire) begin
            r_tmo <= '0;
        end else if (!w_tmo_hit) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_is_wr    <= 1'b0;
            r_lat      <= '0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_fx_wr    <= 1'b0;
            r_fx_rd    <= 1'b0;
            r_fx_waddr <= '0;
            r_fx_raddr <= '0;
            r_fx_data  <= '0;
        end else begin
            r_fx_wr <= 1'b0;
            r_fx_rd <= 1'b0;
            case (r_state)
                S_IDLE: if (w_rx_fire) begin
                    if (bus.rx_data == OP_WRITE || bus.rx_data == OP_READ) begin
                        r_is_wr <= (bus.rx_data == OP_WRITE);
                        r_state <= S_ADDR2;
                    end else begin
                        r_tx_data  <= RSP_ERR;
                        r_tx_valid <= 1'b1;
                        r_state    <= S_ERR;
                    end
                end
                S_ADDR2: if (w_rx_fire) begin
                    r_addr[21:16] <= bus.rx_data[5:0];
                    r_state       <= S_ADDR1;
                end
                S_ADDR1: if (w_rx_fire) begin
                    r_addr[15:8] <= bus.rx_data;
                    r_state      <= S_ADDR0;
                end
                S_ADDR0: if (w_rx_fire) begin
                    r_addr[7:0] <= bus.rx_data;
                    r_state     <= S_LEN;
                end
                S_LEN: if (w_rx_fire) begin
                    r_cnt   <= (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
                    r_state <= r_is_wr ? S_WDATA : S_RISSUE;
                end
                S_WDATA: if (w_rx_fire) begin
                    r_fx_wr    <= 1'b1;
                    r_fx_waddr <= r_addr;
                    r_fx_data  <= bus.rx_data;
                    r_addr     <= r_addr + 22'd1;
                    r_cnt      <= r_cnt - 9'd1;
                    if (r_cnt == 9'd1) begin
                        r_tx_data <= RSP_ACK;
                        r_state   <= S_ACK;
                    end
                end
                S_RISSUE: begin
                    r_fx_rd    <= 1'b1;
                    r_fx_raddr <= r_addr;
                    r_addr     <= r_addr + 22'd1;
                    r_cnt      <= r_cnt - 9'd1;
                    r_lat      <= '0;
                    r_state    <= S_RWAIT;
                end
                S_RWAIT: begin
                    // r_lat counts cycles since the fx_rd pulse was on the bus.
                    if (r_lat == 3'(RD_LAT)) begin
                        r_tx_data  <= bus.fx_q;
                        r_tx_valid <= 1'b1;
                        r_state    <= S_RSEND;
                    end else begin
                        r_lat <= r_lat + 3'd1;
                    end
                end
                S_RSEND: if (w_tx_fire) begin
                    r_tx_valid <= 1'b0;
                    r_state    <= (r_cnt == 9'd0) ? S_IDLE : S_RISSUE;
                end
                S_ACK: begin
                    // One cycle of delay so 'K' never shares a cycle with the last fx_wr.
                    if (!r_tx_valid) begin
                        r_tx_valid <= 1'b1;
                    end else if (w_tx_fire) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                S_ERR: if (w_tx_fire) begin
                    r_tx_valid <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_tmo_hit) begin
                r_tx_data  <= RSP_ERR;
                r_tx_valid <= 1'b1;
                r_state    <= S_ERR;
            end
        end
    end

    assign bus.rx_ready = w_rx_ready;
    assign bus.tx_valid = r_tx_valid;
    assign bus.tx_data  = r_tx_data;
    assign bus.fx_wr    = r_fx_wr;
    assign bus.fx_rd    = r_fx_rd;
    assign bus.fx_waddr = r_fx_waddr;
    assign bus.fx_raddr = r_fx_raddr;
    assign bus.fx_data  = r_fx_data;
    assign bus.busy     = (r_state != S_IDLE);
endmodule

// File: tb/tb_fx_bus_master.sv
// tb/tb_fx_bus_master.sv - directed bench for fx_bus_master with an RD_LAT=1 responder
module tb_fx_bus_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    fx_bus_master_if bus_if ();

    fx_bus_master #(.RD_LAT(1), .TIMEOUT(16)) dut (
        .clk_sys (clk),
        .rst     (rst),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder: read data is the low address byte, one cycle after fx_rd.
    initial bus_if.fx_q = 8'h00;
    always @(posedge clk) if (bus_if.fx_rd) bus_if.fx_q <= bus_if.fx_raddr[7:0];

    logic [21:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];
    int          wr_cyc_q[$];
    logic [21:0] rd_q[$];
    logic [7:0]  tx_q[$];
    int          lat_q[$];
    int          last_rd_cyc = 0;
    logic        prev_txv = 1'b0;
    int          n_both = 0;
    int          n_early = 0;

    always @(negedge clk) if (!rst) begin
        if (bus_if.fx_wr) begin
            wr_addr_q.push_back(bus_if.fx_waddr);
            wr_data_q.push_back(bus_if.fx_data);
            wr_cyc_q.push_back(cyc);
        end
        if (bus_if.fx_rd) begin
            rd_q.push_back(bus_if.fx_raddr);
            last_rd_cyc = cyc;
        end
        if (bus_if.tx_valid && bus_if.tx_ready) tx_q.push_back(bus_if.tx_data);
        if (bus_if.tx_valid && !prev_txv) lat_q.push_back(cyc - last_rd_cyc);
        prev_txv = bus_if.tx_valid;
        if (bus_if.fx_wr && bus_if.fx_rd) n_both++;
        if (bus_if.fx_wr && bus_if.tx_valid) n_early++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        bus_if.rx_data  = b;
        bus_if.rx_valid = 1'b1;
        n = 0;
        while (!bus_if.rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_eq("rx_ready_wait", 32'(n), 32'd0);
        @(negedge clk);
    endtask

    task automatic end_send();
        bus_if.rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus_if.busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check_eq("idle_wait", 32'(n), 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_txv();
        int n;
        n = 0;
        while (!bus_if.tx_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_eq("txv_wait", 32'(n), 32'd0);
    endtask

    int wb, rb, tb, lb;

    initial begin
        bus_if.rx_data  = 8'h00;
        bus_if.rx_valid = 1'b0;
        bus_if.tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_rx_ready", 32'(bus_if.rx_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_fx_wr",    32'(bus_if.fx_wr),    32'd0);
        check_eq("rst_fx_rd",    32'(bus_if.fx_rd),    32'd0);
        check_eq("rst_fx_waddr", 32'(bus_if.fx_waddr), 32'd0);
        check_eq("rst_fx_raddr", 32'(bus_if.fx_raddr), 32'd0);
        check_eq("rst_fx_data",  32'(bus_if.fx_data),  32'd0);
        check_eq("rst_tx_valid", 32'(bus_if.tx_valid), 32'd0);
        check_eq("rst_tx_data",  32'(bus_if.tx_data),  32'd0);
        check_eq("rst_busy",     32'(bus_if.busy),     32'd0);
        check_eq("idle_rx_ready", 32'(bus_if.rx_ready), 32'd1);

        // Two-byte write
        wb = wr_addr_q.size(); tb = tx_q.size();
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h02); send_byte(8'hAA); send_byte(8'hBB); end_send();
        wait_idle();
        check_eq("wr_count", 32'(wr_addr_q.size() - wb), 32'd2);
        if (wr_addr_q.size() - wb == 2) begin
            check_eq("wr0_addr", 32'(wr_addr_q[wb]),     32'h000100);
            check_eq("wr0_data", 32'(wr_data_q[wb]),     32'hAA);
            check_eq("wr1_addr", 32'(wr_addr_q[wb + 1]), 32'h000101);
            check_eq("wr1_data", 32'(wr_data_q[wb + 1]), 32'hBB);
            check_eq("wr_back_to_back", 32'(wr_cyc_q[wb + 1] - wr_cyc_q[wb]), 32'd1);
        end
        check_eq("wr_tx_count", 32'(tx_q.size() - tb), 32'd1);
        if (tx_q.size() > tb) check_eq("wr_ack", 32'(tx_q[tb]), 32'h4B);

        // Read across the 22-bit address wrap
        rb = rd_q.size(); tb = tx_q.size(); lb = lat_q.size();
        send_byte(8'h52); send_byte(8'h3F); send_byte(8'hFF); send_byte(8'hFF);
        send_byte(8'h03); end_send();
        wait_idle();
        check_eq("rd_count", 32'(rd_q.size() - rb), 32'd3);
        if (rd_q.size() - rb == 3) begin
            check_eq("rd0_addr", 32'(rd_q[rb]),     32'h3FFFFF);
            check_eq("rd1_addr", 32'(rd_q[rb + 1]), 32'h000000);
            check_eq("rd2_addr", 32'(rd_q[rb + 2]), 32'h000001);
        end
        check_eq("rd_tx_count", 32'(tx_q.size() - tb), 32'd3);
        if (tx_q.size() - tb == 3) begin
            check_eq("rd_tx0", 32'(tx_q[tb]),     32'hFF);
            check_eq("rd_tx1", 32'(tx_q[tb + 1]), 32'h00);
            check_eq("rd_tx2", 32'(tx_q[tb + 2]), 32'h01);
        end
        if (lat_q.size() > lb) check_eq("rd_latency", 32'(lat_q[lb]), 32'd2);
        else check_eq("rd_latency_seen", 32'(lat_q.size() - lb), 32'd1);

        // Bad opcode
        wb = wr_addr_q.size(); rb = rd_q.size(); tb = tx_q.size();
        send_byte(8'h13); end_send();
        wait_idle();
        check_eq("bad_tx_count", 32'(tx_q.size() - tb), 32'd1);
        if (tx_q.size() > tb) check_eq("bad_err", 32'(tx_q[tb]), 32'h45);
        check_eq("bad_no_wr", 32'(wr_addr_q.size() - wb), 32'd0);
        check_eq("bad_no_rd", 32'(rd_q.size() - rb), 32'd0);
        check_eq("bad_busy", 32'(bus_if.busy), 32'd0);

        // Host backpressure during a two-byte read
        bus_if.tx_ready = 1'b0;
        rb = rd_q.size(); tb = tx_q.size();
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'h02); end_send();
        wait_txv();
        for (int i = 0; i < 10; i++) begin
            check_eq("stall_tx_data", 32'(bus_if.tx_data), 32'h10);
            check_eq("stall_one_rd", 32'(rd_q.size() - rb), 32'd1);
            @(negedge clk);
        end
        bus_if.tx_ready = 1'b1;
        wait_idle();
        check_eq("stall_rd_count", 32'(rd_q.size() - rb), 32'd2);
        check_eq("stall_tx_count", 32'(tx_q.size() - tb), 32'd2);
        if (tx_q.size() - tb == 2) begin
            check_eq("stall_tx0", 32'(tx_q[tb]),     32'h10);
            check_eq("stall_tx1", 32'(tx_q[tb + 1]), 32'h11);
        end

        // Reset in the middle of a write command
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); end_send();
        check_eq("mid_busy_before", 32'(bus_if.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_rx_ready", 32'(bus_if.rx_ready), 32'd0);
        check_eq("mid_rst_busy",     32'(bus_if.busy),     32'd0);
        check_eq("mid_rst_tx_valid", 32'(bus_if.tx_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_fx_wr", 32'(bus_if.fx_wr), 32'd0);
        check_eq("post_rst_fx_rd", 32'(bus_if.fx_rd), 32'd0);
        rb = rd_q.size(); tb = tx_q.size();
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h01); end_send();
        wait_idle();
        check_eq("post_rst_rd_count", 32'(rd_q.size() - rb), 32'd1);
        if (rd_q.size() > rb) check_eq("post_rst_rd_addr", 32'(rd_q[rb]), 32'h000005);
        if (tx_q.size() > tb) check_eq("post_rst_tx", 32'(tx_q[tb]), 32'h05);

        // LEN=0 means 256 bytes; A2[7:6] ignored
        wb = wr_addr_q.size(); tb = tx_q.size();
        send_byte(8'h57); send_byte(8'hC0); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) send_byte(8'(i));
        end_send();
        wait_idle();
        check_eq("len0_count", 32'(wr_addr_q.size() - wb), 32'd256);
        if (wr_addr_q.size() - wb == 256) begin
            check_eq("len0_first_addr", 32'(wr_addr_q[wb]),       32'h001234);
            check_eq("len0_last_addr",  32'(wr_addr_q[wb + 255]), 32'h001333);
            check_eq("len0_last_data",  32'(wr_data_q[wb + 255]), 32'hFF);
            check_eq("len0_span", 32'(wr_cyc_q[wb + 255] - wr_cyc_q[wb]), 32'd255);
        end
        if (tx_q.size() > tb) check_eq("len0_ack", 32'(tx_q[tb]), 32'h4B);

`ifdef FX_MASTER_TIMEOUT_EN
        wb = wr_addr_q.size(); tb = tx_q.size();
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); end_send();
        repeat (17) @(negedge clk);
        wait_idle();
        check_eq("tmo_tx_count", 32'(tx_q.size() - tb), 32'd1);
        if (tx_q.size() > tb) check_eq("tmo_err", 32'(tx_q[tb]), 32'h45);
        check_eq("tmo_busy", 32'(bus_if.busy), 32'd0);
        check_eq("tmo_no_wr", 32'(wr_addr_q.size() - wb), 32'd0);
`endif

        check_eq("never_wr_and_rd", 32'(n_both), 32'd0);
        check_eq("ack_after_last_wr", 32'(n_early), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fx_bus_master.md
# fx_bus_master

Initiator side of the fx register bus: turns the host command byte stream from the USB FX2 interface into single-cycle write and read strobes on the fx bus, and returns read data and status bytes to the host. It sits between the FX2 FIFO front end and `control_top`. `control_top` and the configuration register bank answer the fx bus as responders. One command is handled at a time, with 22-bit address auto-increment.

## Interface
Parameters:
- `RD_LAT`, default 1: cycles from the `fx_rd` pulse to valid `fx_q` (1..4).
- `TIMEOUT`, default 65535: idle cycles allowed inside a command before it is aborted (used only with the macro).

Ports:
- `clk_sys` in 1: system clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rx_data` in 8: host command byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: block accepts `rx_data`. A byte transfers on `rx_valid & rx_ready`.
- `tx_data` out 8: response byte.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: host side accepts. A byte transfers on `tx_valid & tx_ready`.
- `fx_waddr` out 22: write address.
- `fx_wr` out 1: write strobe, one cycle per byte.
- `fx_data` out 8: write data.
- `fx_raddr` out 22: read address.
- `fx_rd` out 1: read strobe, one cycle per byte.
- `fx_q` in 8: read data from the responder.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
Command format, MSB first: opcode, A2, A1, A0, LEN, then LEN data bytes for writes only.
- Address = {A2[5:0], A1, A0}. A2[7:6] are ignored.
- LEN = 0 means 256 bytes.
- Opcodes:
  - 0x57 ('W') is a write.
  - 0x52 ('R') is a read.
  - Any other opcode returns the single byte 0x45 ('E') and the FSM goes back to IDLE without reading the rest of the command.

FSM states: IDLE, ADDR2, ADDR1, ADDR0, LEN, WDATA, RISSUE, RWAIT, RSEND, ACK, ERR.
- IDLE → ADDR2 on a valid opcode; IDLE → ERR on an invalid opcode.
- ADDR2 → ADDR1 → ADDR0 → LEN, one accepted byte each.
- LEN → WDATA for a write; LEN → RISSUE for a read.
- WDATA: each accepted byte produces one `fx_wr` pulse, then the address increments and the count decrements.
  - After the last byte the FSM goes to ACK and returns 0x4B ('K').
- RISSUE: one `fx_rd` pulse → RWAIT for `RD_LAT` cycles → capture `fx_q` into `tx_data` → RSEND.
  - RSEND holds `tx_valid` until `tx_ready`, then goes back to RISSUE, or to IDLE after the last byte.
  - A read returns no status byte.
- ACK and ERR hold `tx_valid` until `tx_ready`, then go to IDLE.
- The address counter is 22 bits and wraps from 0x3FFFFF to 0x000000. The byte counter is 9 bits.
- `rx_ready` is high only in IDLE, ADDR2..ADDR0, LEN and WDATA.
- `tx_valid` is high only in RSEND, ACK and ERR.
- `tx_data` is stable while `tx_valid` is high and `tx_ready` is low.

## Timing
- Reset values:
  - `fx_wr`=0, `fx_rd`=0, `fx_waddr`=0, `fx_raddr`=0, `fx_data`=0.
  - `tx_valid`=0, `tx_data`=0, `rx_ready`=0 during reset, `busy`=0.
  - FSM in IDLE.
- Reset mid-command discards the command. No strobe is issued in the cycle after reset deasserts.
- All fx outputs are registered. `fx_wr` is asserted in the cycle after the data byte is accepted, with `fx_waddr`/`fx_data` valid in that same cycle.
- Write throughput is 1 byte per cycle when `rx_valid` is held high.
- 'K' is presented (`tx_valid`=1) no earlier than the cycle after the last `fx_wr` pulse.
- Read latency per byte: the `fx_rd` pulse, then `fx_q` is sampled `RD_LAT` cycles later, then `tx_valid` is asserted the next cycle.
- `fx_wr` and `fx_rd` are never high in the same cycle.

## Configuration
- `FX_MASTER_TIMEOUT_EN`, defined: a counter runs in ADDR2..LEN and WDATA.
  - It reloads on every accepted `rx` byte.
  - When it reaches `TIMEOUT` with no byte accepted, the FSM goes to ERR, sends 0x45 and returns to IDLE.
  - Writes already issued are not undone.
- Undefined: the FSM waits indefinitely for command bytes and the counter logic is absent.

## Test plan
- Write: 57 00 01 00 02 AA BB → `fx_wr` pulses at 0x000100/AA and 0x000101/BB on consecutive cycles, then `tx` returns 4B.
- Read with `RD_LAT`=1 and a responder model returning `fx_q`=addr[7:0]: 52 3F FF FF 03 → reads at 0x3FFFFF, 0x000000, 0x000001; `tx` returns FF 00 01.
- Bad opcode 13 → `tx` returns 45, no `fx` strobes, `busy` back to 0.
- `tx_ready` held low for 10 cycles during a 2-byte read → `tx_data` is held stable, and no second `fx_rd` is issued until the first byte transfers.
- `rst` asserted after 57 00 00 → all outputs return to their reset values; a following 52 00 00 05 01 reads address 0x000005.
- With `FX_MASTER_TIMEOUT_EN`, `TIMEOUT`=16: 57 00 00 → silence for 17 cycles → `tx` returns 45, FSM back in IDLE.
